imdct_fft_bank_ram: RTL and testbench

Parametrised successor to the four-bank IMDCT/FFT shared data RAM. It holds `2^NB_LOG2` single-port-read banks of configurable depth and width. It arbitrates between a host port and two 2-lane transform engines (IMDCT, FFT), with runtime-selectable transform size and bit-reversed host addressing. An internal sequencer runs either a single engine (manual) or the full pre-IMDCT → FFT → post-IMDCT chain (auto). It adds abort, bank-conflict detection and host-access error reporting.

---
 rtl/imdct_fft_bank_ram_if.sv | 31 +++
 rtl/imdct_fft_bank_ram.sv | 218 +++++++++++++++++++++
 tb/tb_imdct_fft_bank_ram.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imdct_fft_bank_ram_if.sv
// Host and engine-lane bus of the shared IMDCT/FFT bank RAM.
// The master drives accesses; the slave (the RAM) returns read data and status.
interface imdct_fft_bank_ram_if #(
  parameter int DW = 32,
  parameter int AW = 10
);
  logic              host_en;
  logic              host_we;
  logic [AW-1:0]     host_addr;
  logic [DW-1:0]     host_din;
  logic [DW-1:0]     host_dout;
  logic              host_rvalid;
  logic              host_err;
  logic [3:0]        eng_we;
  logic [4*AW-1:0]   eng_raddr;
  logic [4*AW-1:0]   eng_waddr;
  logic [4*DW-1:0]   eng_din;
  logic [2*DW-1:0]   eng_dout;

  modport master (
    output host_en, host_we, host_addr, host_din,
    output eng_we, eng_raddr, eng_waddr, eng_din,
    input  host_dout, host_rvalid, host_err, eng_dout
  );

  modport slave (
    input  host_en, host_we, host_addr, host_din,
    input  eng_we, eng_raddr, eng_waddr, eng_din,
    output host_dout, host_rvalid, host_err, eng_dout
  );
endinterface

// File: rtl/imdct_fft_bank_ram.sv
// Banked data RAM shared by a host port and two 2-lane transform engines,
// with an IDLE/PRE/FFT/POST/SINGLE sequencer, abort and conflict reporting.
module imdct_fft_bank_ram #(
  parameter int DW = 32,
  parameter int ROW_AW = 8,
  parameter int NB_LOG2 = 2,
  localparam int AW = ROW_AW + NB_LOG2,
  localparam int SW = $clog2(AW + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  imdct_fft_bank_ram_if.slave  bus,
  input  logic                 bit_rev,
  input  logic [SW-1:0]        size_log2,
  input  logic                 start,
  input  logic                 auto,
  input  logic                 func,
  input  logic                 mode,
  input  logic                 abort,
  output logic                 done,
  output logic                 progress,
  output logic                 aborted,
  output logic                 conflict,
  output logic                 imdct_start,
  output logic                 imdct_mode,
  input  logic                 imdct_done,
  output logic                 fft_start,
  input  logic                 fft_done
);
  localparam int NB = 1 << NB_LOG2;
  localparam int DEPTH = 1 << ROW_AW;
  localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_FFT = 3'd2, S_POST = 3'd3, S_SINGLE = 3'd4;

  logic [2:0] state_r, state_s;
  logic func_r, mode_r, func_s, mode_s;
  logic busy_s, start_acc_s, fin_s, enter_s;
  logic done_r, progress_r, aborted_r, conflict_r, host_err_r;
  logic imdct_start_r, imdct_mode_r, fft_start_r;

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:   if (start) state_s = auto ? S_PRE : S_SINGLE; else state_s = S_IDLE;
        S_PRE:    if (imdct_done) state_s = S_FFT; else state_s = S_PRE;
        S_FFT:    if (fft_done) state_s = S_POST; else state_s = S_FFT;
        S_POST:   if (imdct_done) state_s = S_IDLE; else state_s = S_POST;
        S_SINGLE: if (func_r ? fft_done : imdct_done) state_s = S_IDLE; else state_s = S_SINGLE;
        default:  state_s = S_IDLE;
      endcase
    end
  end

  assign busy_s      = (state_r != S_IDLE);
  assign start_acc_s = !busy_s && start && !abort;
  assign fin_s       = busy_s && !abort && (state_s == S_IDLE);
  assign enter_s     = (state_s != state_r) && (state_s != S_IDLE);
  assign func_s      = start_acc_s ? func : func_r;
  assign mode_s      = start_acc_s ? mode : mode_r;

  // Host address translation: optional reversal of the low size_log2 bits and range check.
  logic [AW-1:0] haddr_s, rev_full_s, mask_s, phys_s;
  logic [SW-1:0] shamt_s;
  logic oor_s, host_ok_s, host_wr_s, host_rd_s, host_bad_s;
  logic [NB_LOG2-1:0] hbank_s;
  logic [ROW_AW-1:0] hrow_s;
  always_comb begin
    haddr_s    = bus.host_addr;
    rev_full_s = {<<{haddr_s}};
    shamt_s    = SW'(AW) - size_log2;
    mask_s     = {AW{1'b1}} >> shamt_s;
    oor_s      = (haddr_s & ~mask_s) != {AW{1'b0}};
    if (bit_rev) phys_s = (haddr_s & ~mask_s) | ((rev_full_s >> shamt_s) & mask_s);
    else         phys_s = haddr_s;
  end

  assign hbank_s    = phys_s[NB_LOG2-1:0];
  assign hrow_s     = phys_s[AW-1:NB_LOG2];
  assign host_ok_s  = bus.host_en && !busy_s;
  assign host_wr_s  = host_ok_s && bus.host_we && !oor_s;
  assign host_rd_s  = host_ok_s && !bus.host_we;
  assign host_bad_s = bus.host_en && (busy_s || oor_s);

  // Owner-engine lane selection; the non-owning engine's lanes never reach the banks.
  logic own_fft_s, lane_conf_s;
  logic [1:0] lwe_s;
  logic [AW-1:0] lwa0_s, lwa1_s, lra0_s, lra1_s;
  logic [DW-1:0] lwd0_s, lwd1_s;
  always_comb begin
    own_fft_s = (state_r == S_FFT) || ((state_r == S_SINGLE) && func_r);
    if (own_fft_s) begin
      lwe_s  = bus.eng_we[3:2] & {2{busy_s}};
      lwa0_s = bus.eng_waddr[2*AW +: AW];
      lwa1_s = bus.eng_waddr[3*AW +: AW];
      lra0_s = bus.eng_raddr[2*AW +: AW];
      lra1_s = bus.eng_raddr[3*AW +: AW];
      lwd0_s = bus.eng_din[2*DW +: DW];
      lwd1_s = bus.eng_din[3*DW +: DW];
    end else begin
      lwe_s  = bus.eng_we[1:0] & {2{busy_s}};
      lwa0_s = bus.eng_waddr[0 +: AW];
      lwa1_s = bus.eng_waddr[AW +: AW];
      lra0_s = bus.eng_raddr[0 +: AW];
      lra1_s = bus.eng_raddr[AW +: AW];
      lwd0_s = bus.eng_din[0 +: DW];
      lwd1_s = bus.eng_din[DW +: DW];
    end
    lane_conf_s = busy_s && ((lwe_s[0] && lwe_s[1] && (lwa0_s[NB_LOG2-1:0] == lwa1_s[NB_LOG2-1:0]))
                             || (lra0_s[NB_LOG2-1:0] == lra1_s[NB_LOG2-1:0]));
  end

  logic [NB-1:0][DW-1:0] q_all_s;

  for (genvar g = 0; g < NB; g++) begin : g_bank
    localparam logic [NB_LOG2-1:0] ID = NB_LOG2'(g);
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q_r, wdat_s;
    logic we_s, re_s;
    logic [ROW_AW-1:0] wrow_s, rrow_s;

    // Write-port arbitration: lane 0 beats lane 1 on the same bank, host only when idle.
    always_comb begin
      we_s = 1'b0; wrow_s = {ROW_AW{1'b0}}; wdat_s = {DW{1'b0}};
      if (lwe_s[0] && (lwa0_s[NB_LOG2-1:0] == ID)) begin
        we_s = 1'b1; wrow_s = lwa0_s[AW-1:NB_LOG2]; wdat_s = lwd0_s;
      end else if (lwe_s[1] && (lwa1_s[NB_LOG2-1:0] == ID)) begin
        we_s = 1'b1; wrow_s = lwa1_s[AW-1:NB_LOG2]; wdat_s = lwd1_s;
      end else if (host_wr_s && (hbank_s == ID)) begin
        we_s = 1'b1; wrow_s = hrow_s; wdat_s = bus.host_din;
      end else begin
        we_s = 1'b0;
      end
    end

    // Read-port arbitration: a lane 1 read of lane 0's bank shares lane 0's row.
    always_comb begin
      re_s = 1'b0; rrow_s = {ROW_AW{1'b0}};
      if (busy_s && (lra0_s[NB_LOG2-1:0] == ID)) begin
        re_s = 1'b1; rrow_s = lra0_s[AW-1:NB_LOG2];
      end else if (busy_s && (lra1_s[NB_LOG2-1:0] == ID)) begin
        re_s = 1'b1; rrow_s = lra1_s[AW-1:NB_LOG2];
      end else if (host_rd_s && !oor_s && (hbank_s == ID)) begin
        re_s = 1'b1; rrow_s = hrow_s;
      end else begin
        re_s = 1'b0;
      end
    end

    // Bank storage with registered read; a same-row write returns the old word.
    always_ff @(posedge clk) begin
      if (we_s) mem[wrow_s] <= wdat_s;
      if (re_s) q_r <= mem[rrow_s];
    end

    assign q_all_s[g] = q_r;
  end

  logic [NB_LOG2-1:0] hsel_r, lsel0_r, lsel1_r;
  logic hoor_r, rvalid_r;
  logic [DW-1:0] hold_r, hdata_s;

  assign hdata_s = hoor_r ? {DW{1'b0}} : q_all_s[hsel_r];

  // Read-side bookkeeping: registered bank selects and the held host read word.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsel_r <= {NB_LOG2{1'b0}}; lsel0_r <= {NB_LOG2{1'b0}}; lsel1_r <= {NB_LOG2{1'b0}};
      hoor_r <= 1'b0; rvalid_r <= 1'b0; hold_r <= {DW{1'b0}};
    end else begin
      rvalid_r <= host_rd_s;
      if (host_rd_s) begin
        hsel_r <= hbank_s;
        hoor_r <= oor_s;
      end
      lsel0_r <= lra0_s[NB_LOG2-1:0];
      lsel1_r <= lra1_s[NB_LOG2-1:0];
      if (rvalid_r) hold_r <= hdata_s;
    end
  end

  // Sequencer state, latched run parameters and registered status/control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE; func_r <= 1'b0; mode_r <= 1'b0;
      done_r <= 1'b0; progress_r <= 1'b0; aborted_r <= 1'b0;
      conflict_r <= 1'b0; host_err_r <= 1'b0;
      imdct_start_r <= 1'b0; imdct_mode_r <= 1'b0; fft_start_r <= 1'b0;
    end else begin
      state_r <= state_s;
      func_r <= func_s;
      mode_r <= mode_s;
      progress_r <= (state_s != S_IDLE);
      done_r <= fin_s;
      aborted_r <= abort && busy_s;
      imdct_start_r <= enter_s && ((state_s == S_PRE) || (state_s == S_POST)
                                   || ((state_s == S_SINGLE) && !func_s));
      fft_start_r <= enter_s && ((state_s == S_FFT) || ((state_s == S_SINGLE) && func_s));
      imdct_mode_r <= (state_s == S_POST) || ((state_s == S_SINGLE) && mode_s);
      conflict_r <= start_acc_s ? 1'b0 : (conflict_r || lane_conf_s);
      host_err_r <= start_acc_s ? 1'b0 : (host_err_r || host_bad_s);
    end
  end

  assign done            = done_r;
  assign progress        = progress_r;
  assign aborted         = aborted_r;
  assign conflict        = conflict_r;
  assign imdct_start     = imdct_start_r;
  assign imdct_mode      = imdct_mode_r;
  assign fft_start       = fft_start_r;
  assign bus.host_rvalid = rvalid_r;
  assign bus.host_err    = host_err_r;
  assign bus.host_dout   = rvalid_r ? hdata_s : hold_r;
  assign bus.eng_dout    = progress_r ? {q_all_s[lsel1_r], q_all_s[lsel0_r]} : {(2*DW){1'b0}};
endmodule

// File: tb/tb_imdct_fft_bank_ram.sv
// Directed bench for imdct_fft_bank_ram: host reads are checked by a scoreboard
// monitor, sequencer timing and flags by directed comparisons.
module tb_imdct_fft_bank_ram;
  localparam int DW = 32;
  localparam int ROW_AW = 8;
  localparam int NB_LOG2 = 2;
  localparam int AW = ROW_AW + NB_LOG2;
  localparam int SW = $clog2(AW + 1);

  logic clk = 1'b0;
  logic rst, bit_rev, start, auto_run, func, mode, abort;
  logic [SW-1:0] size_log2;
  logic done, progress, aborted, conflict, imdct_start, imdct_mode, fft_start;
  logic imdct_done, fft_done;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  imdct_fft_bank_ram_if #(.DW(DW), .AW(AW)) bus ();

  imdct_fft_bank_ram #(.DW(DW), .ROW_AW(ROW_AW), .NB_LOG2(NB_LOG2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .bit_rev(bit_rev), .size_log2(size_log2),
    .start(start), .auto(auto_run), .func(func), .mode(mode), .abort(abort),
    .done(done), .progress(progress), .aborted(aborted), .conflict(conflict),
    .imdct_start(imdct_start), .imdct_mode(imdct_mode), .imdct_done(imdct_done),
    .fft_start(fft_start), .fft_done(fft_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4*AW-1:0] pack4(input logic [AW-1:0] f1, input logic [AW-1:0] f0,
                                             input logic [AW-1:0] i1, input logic [AW-1:0] i0);
    return {f1, f0, i1, i0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Engine models: done pulse 10 cycles after the start pulse.
  initial begin
    imdct_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (imdct_start) begin
        repeat (10) @(posedge clk);
        #1 imdct_done = 1'b1;
        @(posedge clk); #1 imdct_done = 1'b0;
      end
    end
  end

  initial begin
    fft_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (fft_start) begin
        repeat (10) @(posedge clk);
        #1 fft_done = 1'b1;
        @(posedge clk); #1 fft_done = 1'b0;
      end
    end
  end

  // Host read scoreboard.
  logic [DW-1:0] exp_q[$];
  int iss_q[$];
  logic [DW-1:0] mon_exp;
  int mon_iss;

  always @(negedge clk) begin
    if (!rst && bus.host_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("host_rd_unexpected", 64'(bus.host_dout), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_iss = iss_q.pop_front();
        chk("host_rd_data", 64'(bus.host_dout), 64'(mon_exp));
        chk("host_rd_latency", 64'(cyc - mon_iss), 64'd1);
      end
    end
  end

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.host_en = 1'b1; bus.host_we = 1'b1; bus.host_addr = a; bus.host_din = d;
    @(negedge clk);
    bus.host_en = 1'b0; bus.host_we = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
    bus.host_en = 1'b1; bus.host_we = 1'b0; bus.host_addr = a;
    exp_q.push_back(e); iss_q.push_back(cyc);
    @(negedge clk);
    bus.host_en = 1'b0;
  endtask

  task automatic do_start(input logic a, input logic f, input logic m);
    start = 1'b1; auto_run = a; func = f; mode = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  int t_is1, t_is2, t_fs, t_id1, t_id2, t_fd, t_done, t_ab, gaps, n_done;
  logic mode1, mode2, prog_end;

  task automatic watch_run(input int budget, input bit inject_dead, input int abort_after);
    t_is1 = -1; t_is2 = -1; t_fs = -1; t_id1 = -1; t_id2 = -1; t_fd = -1;
    t_done = -1; t_ab = -1; gaps = 0; n_done = 0; mode1 = 1'b0; mode2 = 1'b0; prog_end = 1'b1;
    for (int i = 0; i < budget; i++) begin
      bus.host_en = 1'b0; bus.host_we = 1'b0; abort = 1'b0;
      if (imdct_start) begin
        if (t_is1 < 0) begin t_is1 = cyc; mode1 = imdct_mode; end
        else begin t_is2 = cyc; mode2 = imdct_mode; end
      end
      if (imdct_done) begin
        if (t_id1 < 0) t_id1 = cyc; else t_id2 = cyc;
      end
      if (fft_start) begin
        t_fs = cyc;
        if (inject_dead) begin
          bus.host_en = 1'b1; bus.host_we = 1'b1; bus.host_addr = AW'(3); bus.host_din = 32'h0000_DEAD;
        end
      end
      if (fft_done) t_fd = cyc;
      if (abort_after > 0 && t_fs >= 0 && cyc == t_fs + abort_after) abort = 1'b1;
      if (done) begin t_done = cyc; n_done++; prog_end = progress; end
      if (aborted) begin t_ab = cyc; prog_end = progress; end
      if (!progress && t_done < 0 && t_ab < 0) gaps++;
      if (t_done >= 0 || t_ab >= 0) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int budget, output int seen);
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin seen = cyc; break; end
      @(negedge clk);
    end
  endtask

  localparam logic [4*AW-1:0] RD_DEF = {10'd1, 10'd0, 10'd1, 10'd0};

  int s, seen, extra_done;

  initial begin
    rst = 1'b1; bit_rev = 1'b0; size_log2 = SW'(AW); start = 1'b0; auto_run = 1'b0;
    func = 1'b0; mode = 1'b0; abort = 1'b0;
    bus.host_en = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_din = '0;
    bus.eng_we = 4'b0000; bus.eng_raddr = RD_DEF; bus.eng_waddr = '0; bus.eng_din = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    chk("rst_flags", 64'({done, progress, aborted, conflict, imdct_start, imdct_mode,
                          fft_start, bus.host_rvalid, bus.host_err}), 64'h0);
    chk("rst_host_dout", 64'(bus.host_dout), 64'h0);
    chk("rst_eng_dout", 64'(bus.eng_dout), 64'h0);

    // Plain host write / read, then read data holds
    host_write(AW'(5), 32'hA5A5_0005);
    host_read(AW'(5), 32'hA5A5_0005);
    repeat (2) @(negedge clk);
    chk("host_dout_hold", 64'(bus.host_dout), 64'hA5A5_0005);
    chk("host_rvalid_pulse", 64'(bus.host_rvalid), 64'h0);

    // Bit-reversed addressing and out-of-range access
    size_log2 = SW'(6); bit_rev = 1'b1;
    host_write(AW'(1), 32'h11);
    host_read(AW'(1), 32'h11);
    bit_rev = 1'b0;
    host_read(AW'(32), 32'h11);
    chk("host_err_clear", 64'(bus.host_err), 64'h0);
    host_read(AW'(64), 32'h0);
    chk("host_err_oor", 64'(bus.host_err), 64'h1);

    // Auto chain with a host write attempted during the FFT phase
    host_write(AW'(3), 32'h33);
    do_start(1'b1, 1'b0, 1'b0);
    s = cyc;
    chk("auto_progress_start", 64'(progress), 64'h1);
    chk("auto_err_cleared", 64'(bus.host_err), 64'h0);
    watch_run(80, 1'b1, 0);
    chk("auto_done_seen", 64'(t_done >= 0), 64'h1);
    chk("auto_imdct1_cyc", 64'(t_is1 - s), 64'h0);
    chk("auto_imdct1_mode", 64'(mode1), 64'h0);
    chk("auto_fft_after_idone", 64'(t_fs - t_id1), 64'h1);
    chk("auto_imdct2_after_fdone", 64'(t_is2 - t_fd), 64'h1);
    chk("auto_imdct2_mode", 64'(mode2), 64'h1);
    chk("auto_done_after_idone2", 64'(t_done - t_id2), 64'h1);
    chk("auto_progress_gaps", 64'(gaps), 64'h0);
    chk("auto_progress_end", 64'(prog_end), 64'h0);
    @(negedge clk);
    chk("auto_done_pulse", 64'(done), 64'h0);
    chk("auto_host_err", 64'(bus.host_err), 64'h1);
    chk("auto_no_conflict", 64'(conflict), 64'h0);
    host_read(AW'(3), 32'h33);

    // Manual FFT run with lane write and read conflicts
    host_write(AW'(8), 32'h88);
    do_start(1'b0, 1'b1, 1'b0);
    s = cyc;
    chk("fft_start_pulse", 64'({fft_start, imdct_start}), 64'h2);
    bus.eng_we = 4'b1100;
    bus.eng_waddr = pack4(AW'(8), AW'(4), AW'(0), AW'(0));
    bus.eng_din = {32'hB, 32'hA, 32'h0, 32'h0};
    @(negedge clk);
    bus.eng_we = 4'b0000;
    bus.eng_raddr = pack4(AW'(32), AW'(5), AW'(1), AW'(0));
    chk("lane_wr_conflict", 64'(conflict), 64'h1);
    @(negedge clk);
    chk("lane_read", 64'(bus.eng_dout), {32'h11, 32'hA5A5_0005});
    bus.eng_raddr = pack4(AW'(8), AW'(4), AW'(1), AW'(0));
    @(negedge clk);
    chk("lane_rd_conflict", 64'(bus.eng_dout), {32'hA, 32'hA});
    bus.eng_raddr = RD_DEF;
    wait_done(40, seen);
    chk("fft_single_done_cyc", 64'(seen - s), 64'd11);
    @(negedge clk);
    chk("eng_dout_idle", 64'(bus.eng_dout), 64'h0);
    host_read(AW'(4), 32'hA);
    host_read(AW'(8), 32'h88);
    chk("conflict_sticky", 64'(conflict), 64'h1);

    // Abort three cycles into the FFT phase
    do_start(1'b1, 1'b0, 1'b0);
    watch_run(80, 1'b0, 3);
    chk("abort_seen", 64'(t_ab >= 0), 64'h1);
    chk("abort_cyc", 64'(t_ab - t_fs), 64'd4);
    chk("abort_progress", 64'(prog_end), 64'h0);
    extra_done = n_done;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    chk("abort_no_done", 64'(extra_done), 64'h0);

    // Restart after abort: manual IMDCT, mode 1
    do_start(1'b0, 1'b0, 1'b1);
    s = cyc;
    chk("restart_ctrl", 64'({progress, imdct_start, imdct_mode, fft_start}), 64'hE);
    chk("restart_conflict_clr", 64'(conflict), 64'h0);
    wait_done(40, seen);
    chk("imdct_single_done_cyc", 64'(seen - s), 64'd11);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
